branch_predictor_btb: RTL and testbench

- Parametrised branch target buffer with per-entry saturating-counter direction prediction for the pipelined RV32 core.
- IF stage looks it up every cycle to pick the next PC.
- Ex stage trains it with the resolved branch/jump outcome.
- Adds performance counters and a mispredict flag that drives the IF/ID and ID/Ex flush.
- Replaces the fixed "predict not-taken, resolve in Ex" policy.

---
 rtl/branch_predictor_btb.sv | 154 +++++++++++++++
 tb/tb_branch_predictor_btb.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_btb.sv
// Branch target buffer with per-entry saturating direction counters.
//
// The IF stage looks the buffer up every cycle (combinational, zero latency)
// to choose the next fetch PC. The Ex stage trains it with the resolved
// outcome of each branch or jump. It also flags a mispredict that triggers
// the redirect and flush, and counts resolved and mispredicted instructions.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   if_pc               PC being fetched
//   pred_taken          lookup predicts taken
//   pred_target         predicted next PC (stored target, or if_pc+4)
//   upd_valid           Ex holds a resolved control-flow instruction
//   upd_is_jump         jal/jalr (else conditional branch)
//   upd_pc              PC of the resolved instruction
//   upd_taken           actual outcome
//   upd_target          actual taken target
//   upd_pred_taken      prediction carried down the pipe
//   upd_pred_target     predicted target carried down the pipe
//   mispredict          Ex-stage redirect required
//   perf_branches       saturating count of resolved instructions
//   perf_mispredicts    saturating count of mispredicts
module branch_predictor_btb #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int PERF_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   if_pc,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic              upd_is_jump,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic [XLEN-1:0]   upd_target,
  input  logic              upd_pred_taken,
  input  logic [XLEN-1:0]   upd_pred_target,
  output logic              mispredict,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  localparam logic [CTR_W-1:0]  CTR_ONE  = CTR_W'(1);
  localparam logic [CTR_W-1:0]  CTR_MAX  = '1;
  localparam logic [CTR_W-1:0]  CTR_WT   = CTR_ONE << (CTR_W - 1);
  localparam logic [CTR_W-1:0]  CTR_WNT  = CTR_WT - CTR_ONE;
  localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);
  localparam logic [PERF_W-1:0] PERF_MAX = '1;
  localparam logic [XLEN-1:0]   PC_STEP  = XLEN'(4);

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [CTR_W-1:0] ctr_q    [ENTRIES];

  // Instruction PCs are word aligned, so bits [1:0] take no part in index or tag.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{if_pc[1:0], upd_pc[1:0]};

  // ---------------------------------------------------------------- lookup
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  assign lk_idx      = if_pc[IDX_W+1:2];
  assign lk_tag      = if_pc[XLEN-1:IDX_W+2];
  assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = lk_hit & ctr_q[lk_idx][CTR_W-1];
  assign pred_target = pred_taken ? target_q[lk_idx] : (if_pc + PC_STEP);

  // ---------------------------------------------------------------- resolve
  assign mispredict = upd_valid &
                      ((upd_pred_taken != upd_taken) |
                       (upd_taken & (upd_pred_target != upd_target)));

  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic [CTR_W-1:0] up_ctr;

  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[XLEN-1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_ctr = ctr_q[up_idx];

  logic             ctr_wr;
  logic             tgt_wr;
  logic             alloc;
  logic [CTR_W-1:0] ctr_nxt;

  always_comb begin
    ctr_wr  = 1'b0;
    tgt_wr  = 1'b0;
    alloc   = 1'b0;
    ctr_nxt = up_ctr;
    if (upd_valid) begin
      if (up_hit) begin
        ctr_wr = 1'b1;
        if (upd_is_jump) begin
          ctr_nxt = CTR_MAX;
          tgt_wr  = 1'b1;
        end else if (upd_taken) begin
          ctr_nxt = (up_ctr == CTR_MAX) ? up_ctr : up_ctr + CTR_ONE;
          tgt_wr  = 1'b1;
        end else begin
          ctr_nxt = (up_ctr == '0) ? up_ctr : up_ctr - CTR_ONE;
        end
      end else if (upd_taken) begin
        // Not-taken misses are not worth an entry; only taken ones allocate.
        ctr_wr  = 1'b1;
        tgt_wr  = 1'b1;
        alloc   = 1'b1;
        ctr_nxt = upd_is_jump ? CTR_MAX : CTR_WT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (ctr_wr) begin
      ctr_q[up_idx] <= ctr_nxt;
      if (alloc) valid_q[up_idx] <= 1'b1;
    end
  end

  // Tag and target need no reset: an entry is ignored until its valid bit is set.
  always_ff @(posedge clk) begin
    if (tgt_wr) target_q[up_idx] <= upd_target;
    if (alloc)  tag_q[up_idx]    <= up_tag;
  end

  // ---------------------------------------------------------------- perf
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else if (upd_valid) begin
      if (perf_branches != PERF_MAX) perf_branches <= perf_branches + PERF_ONE;
      if (mispredict && (perf_mispredicts != PERF_MAX))
        perf_mispredicts <= perf_mispredicts + PERF_ONE;
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
module tb_branch_predictor_btb;

  localparam int XLEN     = 32;
  localparam int ENTRIES  = 16;
  localparam int CTR_W    = 2;
  localparam int PERF_W   = 4;
  localparam int IDX_W    = 4;
  localparam int CTR_MAX  = 3;
  localparam int PERF_MAX = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [XLEN-1:0]   if_pc = '0;
  logic              pred_taken;
  logic [XLEN-1:0]   pred_target;
  logic              upd_valid = 1'b0;
  logic              upd_is_jump = 1'b0;
  logic [XLEN-1:0]   upd_pc = '0;
  logic              upd_taken = 1'b0;
  logic [XLEN-1:0]   upd_target = '0;
  logic              upd_pred_taken = 1'b0;
  logic [XLEN-1:0]   upd_pred_target = '0;
  logic              mispredict;
  logic [PERF_W-1:0] perf_branches;
  logic [PERF_W-1:0] perf_mispredicts;

  always #5 clk = ~clk;

  branch_predictor_btb #(
    .XLEN(XLEN), .ENTRIES(ENTRIES), .CTR_W(CTR_W), .PERF_W(PERF_W)
  ) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_is_jump(upd_is_jump), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict),
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------- reference model
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  int unsigned m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  int          m_pb, m_pm;

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 1;
    end
    m_pb = 0;
    m_pm = 0;
  endfunction

  function automatic void model_lookup(input int unsigned pc, output bit t, output int unsigned tg);
    int idx;
    bit hit;
    idx = int'((pc / 4) % ENTRIES);
    hit = m_valid[idx] && (m_tag[idx] == pc / (4 * ENTRIES));
    t   = hit && (m_ctr[idx] >= 2);
    tg  = t ? m_target[idx] : pc + 4;
  endfunction

  function automatic bit model_mis();
    if (!upd_valid) return 0;
    if (upd_pred_taken != upd_taken) return 1;
    return upd_taken && (upd_pred_target != upd_target);
  endfunction

  function automatic void model_apply();
    int idx;
    bit hit, mis;
    if (!upd_valid) return;
    mis = model_mis();
    idx = int'((upd_pc / 4) % ENTRIES);
    hit = m_valid[idx] && (m_tag[idx] == upd_pc / (4 * ENTRIES));
    if (hit) begin
      if (upd_is_jump) begin
        m_ctr[idx]    = CTR_MAX;
        m_target[idx] = upd_target;
      end else if (upd_taken) begin
        if (m_ctr[idx] < CTR_MAX) m_ctr[idx]++;
        m_target[idx] = upd_target;
      end else if (m_ctr[idx] > 0) begin
        m_ctr[idx]--;
      end
    end else if (upd_taken) begin
      m_valid[idx]  = 1;
      m_tag[idx]    = upd_pc / (4 * ENTRIES);
      m_target[idx] = upd_target;
      m_ctr[idx]    = upd_is_jump ? CTR_MAX : 2;
    end
    if (m_pb < PERF_MAX) m_pb++;
    if (mis && m_pm < PERF_MAX) m_pm++;
  endfunction

  // ---------------------------------------------------------- directed table
  typedef struct {
    logic [31:0] if_pc, uv, uj, upc, ut, utg, upt, uptg;
    logic [31:0] e_pt, e_ptg, e_mis, e_pb, e_pm;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(
    input logic [31:0] a_if, a_uv, a_uj, a_upc, a_ut, a_utg, a_upt, a_uptg,
    input logic [31:0] a_pt, a_ptg, a_mis, a_pb, a_pm);
    vec_t v;
    v.if_pc = a_if; v.uv = a_uv; v.uj = a_uj; v.upc = a_upc; v.ut = a_ut;
    v.utg = a_utg; v.upt = a_upt; v.uptg = a_uptg;
    v.e_pt = a_pt; v.e_ptg = a_ptg; v.e_mis = a_mis; v.e_pb = a_pb; v.e_pm = a_pm;
    vecs.push_back(v);
  endfunction

  task automatic after_edge();
    @(posedge clk);
    model_apply();
    #1;
  endtask

  bit          r_pt;
  int unsigned r_ptg;

  initial begin
    model_reset();
    //   if_pc       uv uj upc    ut utg     upt uptg     pt ptg       mis pb  pm
    add(32'h40,      0, 0, 32'h0,   0, 32'h0,    0, 32'h0,    0, 32'h44,   0, 0,  0);
    add(32'h40,      1, 0, 32'h40,  1, 32'h10,   0, 32'h44,   0, 32'h44,   1, 0,  0);
    add(32'h40,      0, 0, 32'h0,   0, 32'h0,    0, 32'h0,    1, 32'h10,   0, 1,  1);
    add(32'h40,      1, 0, 32'h40,  1, 32'h10,   1, 32'h10,   1, 32'h10,   0, 1,  1);
    add(32'h40,      1, 0, 32'h40,  1, 32'h10,   1, 32'h10,   1, 32'h10,   0, 2,  1);
    add(32'h40,      1, 0, 32'h40,  1, 32'h10,   1, 32'h10,   1, 32'h10,   0, 3,  1);
    add(32'h40,      1, 0, 32'h40,  0, 32'h10,   1, 32'h10,   1, 32'h10,   1, 4,  1);
    add(32'h40,      0, 0, 32'h0,   0, 32'h0,    0, 32'h0,    1, 32'h10,   0, 5,  2);
    add(32'h40,      1, 0, 32'h40,  0, 32'h10,   1, 32'h10,   1, 32'h10,   1, 5,  2);
    add(32'h40,      0, 0, 32'h0,   0, 32'h0,    0, 32'h0,    0, 32'h44,   0, 6,  3);
    add(32'h40,      1, 0, 32'h80,  1, 32'h200,  0, 32'h84,   0, 32'h44,   1, 6,  3);
    add(32'h40,      0, 0, 32'h0,   0, 32'h0,    0, 32'h0,    0, 32'h44,   0, 7,  4);
    add(32'h80,      0, 0, 32'h0,   0, 32'h0,    0, 32'h0,    1, 32'h200,  0, 7,  4);
    add(32'h104,     1, 1, 32'h104, 1, 32'h3000, 0, 32'h108,  0, 32'h108,  1, 7,  4);
    add(32'h104,     0, 0, 32'h0,   0, 32'h0,    0, 32'h0,    1, 32'h3000, 0, 8,  5);
    add(32'h104,     1, 1, 32'h104, 1, 32'h3000, 1, 32'h3000, 1, 32'h3000, 0, 8,  5);
    add(32'h104,     0, 0, 32'h0,   0, 32'h0,    0, 32'h0,    1, 32'h3000, 0, 9,  5);
    add(32'h80,      1, 0, 32'h80,  1, 32'h240,  1, 32'h200,  1, 32'h200,  1, 9,  5);
    add(32'h80,      0, 0, 32'h0,   0, 32'h0,    0, 32'h0,    1, 32'h240,  0, 10, 6);
    add(32'hFFFFFFFC,0, 0, 32'h0,   0, 32'h0,    0, 32'h0,    0, 32'h0,    0, 10, 6);
    add(32'h80,      0, 1, 32'h80,  1, 32'h999,  0, 32'h0,    1, 32'h240,  0, 10, 6);
    add(32'h80,      0, 0, 32'h0,   0, 32'h0,    0, 32'h0,    1, 32'h240,  0, 10, 6);
    add(32'h80,      1, 0, 32'h300, 0, 32'h304,  0, 32'h304,  1, 32'h240,  0, 10, 6);
    add(32'h300,     0, 0, 32'h0,   0, 32'h0,    0, 32'h0,    0, 32'h304,  0, 11, 6);
    add(32'h80,      0, 0, 32'h0,   0, 32'h0,    0, 32'h0,    1, 32'h240,  0, 11, 6);

    #12 rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      if_pc           = vecs[i].if_pc;
      upd_valid       = vecs[i].uv[0];
      upd_is_jump     = vecs[i].uj[0];
      upd_pc          = vecs[i].upc;
      upd_taken       = vecs[i].ut[0];
      upd_target      = vecs[i].utg;
      upd_pred_taken  = vecs[i].upt[0];
      upd_pred_target = vecs[i].uptg;
      @(negedge clk);
      check($sformatf("vec%0d pred_taken", i),  {31'b0, pred_taken},  vecs[i].e_pt);
      check($sformatf("vec%0d pred_target", i), pred_target,          vecs[i].e_ptg);
      check($sformatf("vec%0d mispredict", i),  {31'b0, mispredict},  vecs[i].e_mis);
      check($sformatf("vec%0d perf_branches", i),    {28'b0, perf_branches},    vecs[i].e_pb);
      check($sformatf("vec%0d perf_mispredicts", i), {28'b0, perf_mispredicts}, vecs[i].e_pm);
      after_edge();
    end

    // ---------------------------------------------------- randomized phase
    for (int n = 0; n < 600; n++) begin
      if_pc       = ($urandom_range(0, 47) * 4) | $urandom_range(0, 3);
      upd_valid   = ($urandom_range(0, 3) != 0);
      upd_is_jump = ($urandom_range(0, 4) == 0);
      upd_pc      = ($urandom_range(0, 47) * 4) | $urandom_range(0, 3);
      upd_taken   = upd_is_jump ? 1'b1 : 1'(($urandom_range(0, 2) != 0));
      upd_target  = $urandom_range(0, 7) * 32'h100;
      model_lookup(upd_pc, r_pt, r_ptg);
      upd_pred_taken  = r_pt;
      upd_pred_target = r_ptg;
      if ($urandom_range(0, 5) == 0) upd_pred_taken  = ~upd_pred_taken;
      if ($urandom_range(0, 5) == 0) upd_pred_target = $urandom;
      @(negedge clk);
      model_lookup(if_pc, r_pt, r_ptg);
      check("rnd pred_taken",  {31'b0, pred_taken}, {31'b0, r_pt});
      check("rnd pred_target", pred_target, r_ptg);
      check("rnd mispredict",  {31'b0, mispredict}, {31'b0, model_mis()});
      check("rnd perf_branches",    {28'b0, perf_branches},    m_pb);
      check("rnd perf_mispredicts", {28'b0, perf_mispredicts}, m_pm);
      after_edge();
    end
    check("perf_branches saturated", {28'b0, perf_branches}, PERF_MAX);

    // ---------------------------------------------------- async reset mid-stream
    for (int n = 0; n < 5; n++) begin
      upd_valid       = 1'b1;
      upd_is_jump     = 1'b0;
      upd_pc          = (n == 0) ? 32'h40 : 32'h40 + n * 4;
      upd_taken       = 1'b1;
      upd_target      = 32'h500 + n * 16;
      upd_pred_taken  = 1'b0;
      upd_pred_target = upd_pc + 4;
      if_pc           = 32'h40;
      after_edge();
    end
    upd_valid = 1'b1;
    upd_pc    = 32'h40;
    upd_target = 32'h700;
    @(negedge clk);
    model_lookup(32'h40, r_pt, r_ptg);
    check("pre-reset hit 0x40", {31'b0, pred_taken}, {31'b0, r_pt});
    #2 rst = 1'b0;
    #1;
    check("async rst pred_taken",       {31'b0, pred_taken}, 32'd0);
    check("async rst pred_target",      pred_target, 32'h44);
    check("async rst perf_branches",    {28'b0, perf_branches}, 32'd0);
    check("async rst perf_mispredicts", {28'b0, perf_mispredicts}, 32'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    model_reset();
    upd_valid = 1'b0;
    @(negedge clk);
    check("post-rst 0x40 miss",        {31'b0, pred_taken}, 32'd0);
    check("post-rst 0x40 target",      pred_target, 32'h44);
    check("post-rst perf_branches",    {28'b0, perf_branches}, 32'd0);
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
